ahb_noc_tx: RTL and testbench

AHB_NOC_TX -- requirements
Module: ahb_noc_tx

---
 rtl/ahb_noc_tx_if.sv | 31 +++
 rtl/ahb_noc_tx.sv | 144 ++++++++++++++
 tb/tb_ahb_noc_tx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_noc_tx_if.sv
// AHB-Lite slave bus plus NoC transmit link for ahb_noc_tx.
//   slave  : view taken by ahb_noc_tx (AHB inputs, HRDATA/HREADYOUT out, flit out)
//   master : view taken by the AHB master / router side
// Signals:
//   HADDR, HWDATA, HSIZE, HTRANS, HWRITE, HREADY, HSEL : AHB-Lite request
//   HRDATA, HREADYOUT                                   : AHB-Lite response
//   tx_flit, tx_valid, tx_ready                         : flit handshake to router
interface ahb_noc_tx_if;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [31:0] tx_flit;
  logic        tx_valid;
  logic        tx_ready;

  modport slave (
    input  HADDR, HWDATA, HSIZE, HTRANS, HWRITE, HREADY, HSEL, tx_ready,
    output HRDATA, HREADYOUT, tx_flit, tx_valid
  );

  modport master (
    output HADDR, HWDATA, HSIZE, HTRANS, HWRITE, HREADY, HSEL, tx_ready,
    input  HRDATA, HREADYOUT, tx_flit, tx_valid
  );
endinterface

// File: rtl/ahb_noc_tx.sv
// AHB-Lite slave that queues writes as NoC flits for a mesh router.
// Register map (HADDR[3:2]):
//   0 TX_DATA  write pushes {dest, src, HWDATA[23:0]}; reads 0
//   1 DEST     {dest_x, dest_y} in bits[3:0]
//   2 STATUS   bit0 full, bit1 empty, bits[6:2] count
//   3 reserved
// Ports:
//   HCLK      clock, rising edge
//   HRESET    synchronous active-high reset
//   Addr_X/Y  local PE coordinates, used as flit source
//   bus       AHB-Lite slave + flit link (ahb_noc_tx_if.slave)
module ahb_noc_tx #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic [1:0] Addr_X,
  input  logic [1:0] Addr_Y,
  ahb_noc_tx_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] OffTxData = 2'd0;
  localparam logic [1:0] OffDest   = 2'd1;
  localparam logic [1:0] OffStatus = 2'd2;

  // Registered data-phase controls
  logic          dp_valid_q, dp_valid_d;
  logic          dp_write_q, dp_write_d;
  logic [1:0]    dp_addr_q, dp_addr_d;

  logic [3:0]    dest_q, dest_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];

  logic          addr_qual;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          push;
  logic          tx_wr_phase;
  logic          hready_out;
  logic [4:0]    count5;

  logic unused_bits;
  assign unused_bits = ^{bus.HSIZE, bus.HADDR[31:4], bus.HADDR[1:0], bus.HWDATA[31:24]};

  always_comb begin
    addr_qual   = bus.HSEL && bus.HREADY && (bus.HTRANS != 2'b00);
    fifo_full   = (count_q == CW'(DEPTH));
    fifo_empty  = (count_q == '0);
    pop         = !fifo_empty && bus.tx_ready;
    tx_wr_phase = dp_valid_q && dp_write_q && (dp_addr_q == OffTxData);
    // Stall only a TX_DATA write into a full FIFO that is not draining this cycle
    hready_out  = !(tx_wr_phase && fifo_full && !pop);
    push        = tx_wr_phase && hready_out;
    count5      = 5'(count_q);
  end

  // Data-phase control capture; held while stalled
  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_addr_d  = dp_addr_q;
    if (hready_out) begin
      dp_valid_d = addr_qual;
      dp_write_d = bus.HWRITE;
      dp_addr_d  = bus.HADDR[3:2];
    end
  end

  always_comb begin
    dest_d = dest_q;
    if (hready_out && dp_valid_q && dp_write_q && (dp_addr_q == OffDest)) begin
      dest_d = bus.HWDATA[3:0];
    end
  end

  // FIFO: at full, a simultaneous push/pop writes the slot being vacated,
  // which is safe because the head is read before the edge.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {dest_q, Addr_X, Addr_Y, bus.HWDATA[23:0]};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= 2'd0;
      dest_q     <= 4'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_addr_q  <= dp_addr_d;
      dest_q     <= dest_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible when count is nonzero
  always_ff @(posedge HCLK) begin
    mem_q <= mem_d;
  end

  always_comb begin
    bus.HREADYOUT = hready_out;
    bus.tx_valid  = !fifo_empty;
    bus.tx_flit   = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];
    bus.HRDATA    = 32'd0;
    if (dp_valid_q && !dp_write_q) begin
      unique case (dp_addr_q)
        OffDest:   bus.HRDATA = {28'd0, dest_q};
        OffStatus: bus.HRDATA = {25'd0, count5, fifo_empty, fifo_full};
        default:   bus.HRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_noc_tx.sv
module tb_ahb_noc_tx;
  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [1:0] Addr_X;
  logic [1:0] Addr_Y;

  ahb_noc_tx_if bus ();

  ahb_noc_tx #(
    .DEPTH(4)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .Addr_X(Addr_X),
    .Addr_Y(Addr_Y),
    .bus   (bus)
  );

  always #5 HCLK = ~HCLK;

  // Single-slave system: HREADY follows the slave's HREADYOUT
  assign bus.HREADY = bus.HREADYOUT;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] addr, input logic wr);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = wr;
    bus.HADDR  = addr;
    bus.HSIZE  = 3'b010;
  endtask

  task automatic idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
  endtask

  task automatic start_write(input logic [31:0] addr, input logic [31:0] data);
    addr_phase(addr, 1'b1);
    tick();
    idle();
    bus.HWDATA = data;
  endtask

  task automatic finish_xfer();
    int n = 0;
    while (bus.HREADYOUT !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("ready_timeout", {31'd0, bus.HREADYOUT}, 32'd1);
    tick();
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    start_write(addr, data);
    finish_xfer();
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    addr_phase(addr, 1'b0);
    tick();
    idle();
    data = bus.HRDATA;
    tick();
  endtask

  logic [31:0] rd;

  initial begin
    HRESET       = 1'b1;
    Addr_X       = 2'd0;
    Addr_Y       = 2'd0;
    bus.HADDR    = 32'd0;
    bus.HWDATA   = 32'd0;
    bus.HSIZE    = 3'b010;
    bus.HTRANS   = 2'b00;
    bus.HWRITE   = 1'b0;
    bus.HSEL     = 1'b0;
    bus.tx_ready = 1'b0;
    tick();
    tick();
    HRESET = 1'b0;

    // Reset state
    check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_tx_flit", bus.tx_flit, 32'd0);
    check("rst_hrdata", bus.HRDATA, 32'd0);
    check("rst_hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);

    // Single flit: dest 7, src {2,1} -> nibble 9
    Addr_X       = 2'd2;
    Addr_Y       = 2'd1;
    bus.tx_ready = 1'b1;
    bus_write(32'h4, 32'h7);
    bus_read(32'h4, rd);
    check("dest_read", rd, 32'h7);
    bus_write(32'h0, 32'h00AB_CDEF);
    check("s1_valid", {31'd0, bus.tx_valid}, 32'd1);
    check("s1_flit", bus.tx_flit, 32'h79AB_CDEF);
    tick();
    check("s1_popped", {31'd0, bus.tx_valid}, 32'd0);

    // Fill to full, then stall the fifth write
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) bus_write(32'h0, i);
    bus_read(32'h8, rd);
    check("status_full", rd, 32'h11);
    start_write(32'h0, 32'd5);
    check("stall", {31'd0, bus.HREADYOUT}, 32'd0);
    tick();
    check("stall_hold", {31'd0, bus.HREADYOUT}, 32'd0);
    bus.tx_ready = 1'b1;
    #1;
    check("stall_release", {31'd0, bus.HREADYOUT}, 32'd1);
    check("drain_1", bus.tx_flit, 32'h7900_0001);
    tick();
    bus.tx_ready = 1'b0;
    bus_read(32'h8, rd);
    check("status_full_after_stall", rd, 32'h11);

    // Drain the rest in order
    bus.tx_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check("drain_valid", {31'd0, bus.tx_valid}, 32'd1);
      check("drain_flit", bus.tx_flit, 32'h7900_0000 + i);
      tick();
    end
    check("drained_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("drained_flit", bus.tx_flit, 32'd0);
    bus_read(32'h8, rd);
    check("status_empty", rd, 32'h02);

    // Streamed push/pop at count 1 across several pointer wraps
    bus.tx_ready = 1'b0;
    bus_write(32'h0, 32'h100);
    addr_phase(32'h0, 1'b1);
    tick();
    for (int j = 1; j <= 10; j++) begin
      bus.HWDATA   = 32'h100 + j;
      bus.tx_ready = 1'b1;
      if (j == 10) idle();
      #1;
      check("stream_valid", {31'd0, bus.tx_valid}, 32'd1);
      check("stream_flit", bus.tx_flit, 32'h7900_0100 + j - 1);
      tick();
    end
    bus.tx_ready = 1'b0;
    check("stream_last", bus.tx_flit, 32'h7900_010A);
    bus_read(32'h8, rd);
    check("stream_count1", rd, 32'h04);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    check("stream_empty", {31'd0, bus.tx_valid}, 32'd0);

    // Reserved / write-only offsets, source change after queueing
    bus_write(32'h0, 32'h42);
    bus_read(32'h0, rd);
    check("rd_txdata_zero", rd, 32'd0);
    bus_read(32'hC, rd);
    check("rd_rsvd_zero", rd, 32'd0);
    bus_write(32'hC, 32'hFFFF_FFFF);
    bus_read(32'h4, rd);
    check("dest_after_rsvd", rd, 32'h7);
    bus_read(32'h8, rd);
    check("status_after_rsvd", rd, 32'h04);
    check("flit_after_rsvd", bus.tx_flit, 32'h7900_0042);
    Addr_X = 2'd3;
    Addr_Y = 2'd3;
    tick();
    check("addr_change_keeps_flit", bus.tx_flit, 32'h7900_0042);
    Addr_X = 2'd2;
    Addr_Y = 2'd1;
    bus_write(32'h4, 32'hFFFF_FFF5);
    bus_read(32'h4, rd);
    check("dest_upper_masked", rd, 32'h5);

    // Reset while a write is stalled behind a full FIFO
    for (int i = 0; i < 3; i++) bus_write(32'h0, 32'h50 + i);
    bus_read(32'h8, rd);
    check("status_full2", rd, 32'h11);
    start_write(32'h0, 32'h99);
    check("stall2", {31'd0, bus.HREADYOUT}, 32'd0);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    check("rst_stall_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_stall_ready", {31'd0, bus.HREADYOUT}, 32'd1);
    check("rst_stall_flit", bus.tx_flit, 32'd0);
    check("rst_stall_hrdata", bus.HRDATA, 32'd0);
    bus_read(32'h8, rd);
    check("rst_status", rd, 32'h02);
    bus_read(32'h4, rd);
    check("rst_dest", rd, 32'd0);
    bus.tx_ready = 1'b1;
    tick();
    check("rst_no_flit", {31'd0, bus.tx_valid}, 32'd0);

    // First push after reset uses the cleared destination
    bus.tx_ready = 1'b0;
    bus_write(32'h0, 32'h123);
    check("post_rst_flit", bus.tx_flit, 32'h0900_0123);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
